// File: rtl/data_sync_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | data_sync_ctrl_pkg : shared encodings and width helpers for the      |
// |                      filtered-synchronizer controller.  Rev 1.0      |
// +----------------------------------------------------------------------+
package data_sync_ctrl_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_INIT   = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_TRACK  = 3'd3;
    localparam state_t ST_ADJUST = 3'd4;

    localparam logic ADJ_UP   = 1'b1;
    localparam logic ADJ_DOWN = 1'b0;

    // Skew (FILT_SIZE+1 bits) plus margin must never wrap, so keep one extra bit.
    function automatic int need_width(input int filt_size);
        return filt_size + 2;
    endfunction

    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_ctrl_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_ctrl_timer : loadable down-counter, saturates at zero and       |
// |                   flags expiry.  Rev 1.0                             |
// +----------------------------------------------------------------------+
module sync_ctrl_timer #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/data_sync_filt_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | data_sync_filt_ctrl : sequences synchronizer init and adapts its     |
// |                       filter depth from observed skew.  Rev 1.0      |
// +----------------------------------------------------------------------+
module data_sync_filt_ctrl
    import data_sync_ctrl_pkg::*;
#(
    parameter int FILT_SIZE   = 4,
    parameter int INIT_CYC    = 4,
    parameter int QUIET_CYC   = 256,
    parameter int SKEW_MARGIN = 1,
    parameter int CNT_W       = 16,
    parameter int FILT_RST    = 1
) (
    input  logic                 clk_d,
    input  logic                 rst_d,
    input  logic                 enable,
    input  logic                 soft_init,
    input  logic [FILT_SIZE-1:0] cfg_filt_min,
    input  logic [FILT_SIZE-1:0] cfg_filt_max,
    input  logic                 sync_data_avail_d,
    input  logic [FILT_SIZE:0]   sync_max_skew_d,
    output logic                 sync_init_d_n,
    output logic [FILT_SIZE-1:0] sync_filt_d,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     avail_cnt,
    output logic                 filt_changed,
    output logic                 err_skew
);

    localparam int NEED_W = need_width(FILT_SIZE);
    localparam int TMR_W  = timer_width(INIT_CYC, QUIET_CYC);
    localparam logic [TMR_W-1:0] INIT_LOAD  = TMR_W'(INIT_CYC - 1);
    localparam logic [TMR_W-1:0] QUIET_LOAD = TMR_W'(QUIET_CYC - 1);

    state_t               state_q,   state_d;
    logic                 init_n_q,  init_n_d;
    logic [FILT_SIZE-1:0] filt_q,    filt_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic                 chg_q,     chg_d;
    logic                 err_q,     err_d;
    logic                 adj_dir_q, adj_dir_d;

    logic [NEED_W-1:0] need;
    logic [NEED_W-1:0] filt_ext;
    logic              need_gt;
    logic              need_lt;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expired;

    assign need     = NEED_W'(sync_max_skew_d) + NEED_W'(SKEW_MARGIN);
    assign filt_ext = NEED_W'(filt_q);
    assign need_gt  = (need > filt_ext);
    assign need_lt  = (need < filt_ext);

    always_comb begin
        state_d   = state_q;
        filt_d    = filt_q;
        cnt_d     = cnt_q;
        chg_d     = 1'b0;
        err_d     = err_q;
        adj_dir_d = adj_dir_q;

        case (state_q)
            ST_IDLE: begin
                filt_d = cfg_filt_min;
                if (enable) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_INIT: begin
                if (tmr_expired) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (soft_init) begin
                    state_d = ST_INIT;
                end else if (sync_data_avail_d || tmr_expired) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                // Counted even on the cycle TRACK is left.
                if (sync_data_avail_d && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (soft_init) begin
                    state_d = ST_INIT;
                end else if (need_gt && (filt_q < cfg_filt_max)) begin
                    state_d   = ST_ADJUST;
                    adj_dir_d = ADJ_UP;
                end else if (need_gt) begin
                    err_d = 1'b1;
                end else if (tmr_expired && need_lt && (filt_q > cfg_filt_min)) begin
                    state_d   = ST_ADJUST;
                    adj_dir_d = ADJ_DOWN;
                end
            end
            ST_ADJUST: begin
                filt_d  = (adj_dir_q == ADJ_UP) ? filt_q + FILT_SIZE'(1)
                                                : filt_q - FILT_SIZE'(1);
                chg_d   = 1'b1;
                state_d = ST_INIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disable wins over everything, including a half-done ADJUST.
        if (!enable) begin
            state_d = ST_IDLE;
            filt_d  = cfg_filt_min;
            chg_d   = 1'b0;
        end
    end

    // Registered from the next state so the pin lines up with the state output.
    assign init_n_d = (state_d == ST_SETTLE) || (state_d == ST_TRACK);

    assign tmr_load = (state_d != state_q);
    assign tmr_val  = (state_d == ST_INIT) ? INIT_LOAD : QUIET_LOAD;

    sync_ctrl_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i      (clk_d),
        .rst_i      (rst_d),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge clk_d or posedge rst_d) begin
        if (rst_d) begin
            state_q   <= ST_IDLE;
            init_n_q  <= 1'b0;
            filt_q    <= FILT_SIZE'(FILT_RST);
            cnt_q     <= '0;
            chg_q     <= 1'b0;
            err_q     <= 1'b0;
            adj_dir_q <= ADJ_UP;
        end else begin
            state_q   <= state_d;
            init_n_q  <= init_n_d;
            filt_q    <= filt_d;
            cnt_q     <= cnt_d;
            chg_q     <= chg_d;
            err_q     <= err_d;
            adj_dir_q <= adj_dir_d;
        end
    end

    assign state         = state_q;
    assign sync_init_d_n = init_n_q;
    assign sync_filt_d   = filt_q;
    assign avail_cnt     = cnt_q;
    assign filt_changed  = chg_q;
    assign err_skew      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_sync_filt_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_sync_filt_ctrl : scenario tasks plus a randomized TRACK run  |
// |                          against a cycle-age reference model. Rev 1.0|
// +----------------------------------------------------------------------+
module tb_data_sync_filt_ctrl;

    localparam int FILT_SIZE   = 4;
    localparam int INIT_CYC    = 4;
    localparam int QUIET_CYC   = 256;
    localparam int SKEW_MARGIN = 1;
    localparam int CNT_W       = 16;
    localparam int FILT_RST    = 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_TRACK  = 3'd3;
    localparam logic [2:0] S_ADJUST = 3'd4;

    logic                 clk_d = 1'b0;
    logic                 rst_d;
    logic                 enable;
    logic                 soft_init;
    logic [FILT_SIZE-1:0] cmin;
    logic [FILT_SIZE-1:0] cmax;
    logic                 avail;
    logic [FILT_SIZE:0]   skew;
    logic                 init_n;
    logic [FILT_SIZE-1:0] filt;
    logic [2:0]           state;
    logic [CNT_W-1:0]     avail_cnt;
    logic                 filt_changed;
    logic                 err_skew;

    int tests = 0;
    int fails = 0;

    data_sync_filt_ctrl #(
        .FILT_SIZE   (FILT_SIZE),
        .INIT_CYC    (INIT_CYC),
        .QUIET_CYC   (QUIET_CYC),
        .SKEW_MARGIN (SKEW_MARGIN),
        .CNT_W       (CNT_W),
        .FILT_RST    (FILT_RST)
    ) dut (
        .clk_d             (clk_d),
        .rst_d             (rst_d),
        .enable            (enable),
        .soft_init         (soft_init),
        .cfg_filt_min      (cmin),
        .cfg_filt_max      (cmax),
        .sync_data_avail_d (avail),
        .sync_max_skew_d   (skew),
        .sync_init_d_n     (init_n),
        .sync_filt_d       (filt),
        .state             (state),
        .avail_cnt         (avail_cnt),
        .filt_changed      (filt_changed),
        .err_skew          (err_skew)
    );

    always #5 clk_d = ~clk_d;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_d);
        #1;
    endtask

    // Walks the DUT out of INIT/ADJUST to SETTLE, then enters TRACK with one avail pulse.
    task automatic to_track();
        int n = 0;
        while (state !== S_SETTLE && n < 600) begin
            tick();
            n++;
        end
        tests++;
        if (state !== S_SETTLE) begin
            fails++;
            $display("FAIL settle_wait: state=%0d required=%0d", state, S_SETTLE);
        end
        avail = 1'b1;
        tick();
        avail = 1'b0;
        tests++;
        if (state !== S_TRACK) begin
            fails++;
            $display("FAIL track_entry: state=%0d required=%0d", state, S_TRACK);
        end
    endtask

    task automatic restart(input logic [FILT_SIZE-1:0] lo, input logic [FILT_SIZE-1:0] hi);
        enable = 1'b0;
        tick();
        cmin   = lo;
        cmax   = hi;
        enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_d = 1'b1; enable = 1'b0; soft_init = 1'b0; avail = 1'b0;
        skew = '0; cmin = 4'd2; cmax = 4'd6;
        repeat (3) tick();
        tests++; if (state !== S_IDLE) begin fails++; $display("FAIL rst_state: got %0d need %0d", state, S_IDLE); end
        tests++; if (init_n !== 1'b0) begin fails++; $display("FAIL rst_init_n: got %0b need 0", init_n); end
        tests++; if (filt !== 4'(FILT_RST)) begin fails++; $display("FAIL rst_filt: got %0d need %0d", filt, FILT_RST); end
        tests++; if (avail_cnt !== '0) begin fails++; $display("FAIL rst_cnt: got %0d need 0", avail_cnt); end
        tests++; if (filt_changed !== 1'b0) begin fails++; $display("FAIL rst_chg: got %0b need 0", filt_changed); end
        tests++; if (err_skew !== 1'b0) begin fails++; $display("FAIL rst_err: got %0b need 0", err_skew); end
        rst_d = 1'b0;
        tick();
        tests++; if (state !== S_IDLE || filt !== 4'd2) begin
            fails++; $display("FAIL idle_min: state=%0d filt=%0d need state=0 filt=2", state, filt);
        end
    endtask

    task automatic test_init_seq();
        int n = 0;
        bit lowbad = 0;
        enable = 1'b1;
        tick();
        tests++; if (state !== S_INIT || filt !== 4'd2) begin
            fails++; $display("FAIL init_entry: state=%0d filt=%0d need state=1 filt=2", state, filt);
        end
        while (state === S_INIT && n < 50) begin
            if (init_n !== 1'b0) lowbad = 1;
            n++;
            tick();
        end
        tests++; if (n != INIT_CYC || lowbad) begin
            fails++; $display("FAIL init_len: cycles=%0d lowbad=%0b need %0d cycles low", n, lowbad, INIT_CYC);
        end
        tests++; if (state !== S_SETTLE || init_n !== 1'b1) begin
            fails++; $display("FAIL settle: state=%0d init_n=%0b need state=2 init_n=1", state, init_n);
        end
        avail = 1'b1;
        tick();
        avail = 1'b0;
        tests++; if (state !== S_TRACK || avail_cnt !== '0) begin
            fails++; $display("FAIL first_avail: state=%0d cnt=%0d need state=3 cnt=0", state, avail_cnt);
        end
    endtask

    task automatic test_adjust_up();
        int n = 0;
        int chg = 0;
        skew = 5'd2;
        tick();
        tests++; if (state !== S_ADJUST || init_n !== 1'b0 || filt !== 4'd2) begin
            fails++; $display("FAIL adj_up: state=%0d init_n=%0b filt=%0d need 4/0/2", state, init_n, filt);
        end
        skew = 5'd0;
        tick();
        tests++; if (state !== S_INIT || filt !== 4'd3 || filt_changed !== 1'b1) begin
            fails++; $display("FAIL adj_up_res: state=%0d filt=%0d chg=%0b need 1/3/1", state, filt, filt_changed);
        end
        while (state === S_INIT && n < 50) begin
            if (filt_changed) chg++;
            n++;
            tick();
        end
        tests++; if (n != INIT_CYC || chg != 1) begin
            fails++; $display("FAIL adj_reinit: cycles=%0d pulses=%0d need %0d/1", n, chg, INIT_CYC);
        end
        to_track();
        repeat (50) tick();
        tests++; if (state !== S_TRACK || filt !== 4'd3) begin
            fails++; $display("FAIL adj_hold: state=%0d filt=%0d need 3/3", state, filt);
        end
    endtask

    task automatic test_err_max();
        bit left = 0;
        restart(4'd6, 4'd6);
        tests++; if (filt !== 4'd6) begin fails++; $display("FAIL max_depth: got %0d need 6", filt); end
        to_track();
        skew = 5'd6;
        tick();
        tests++; if (err_skew !== 1'b1 || state !== S_TRACK) begin
            fails++; $display("FAIL err_set: err=%0b state=%0d need 1/3", err_skew, state);
        end
        skew = 5'd0;
        repeat (10) begin
            tick();
            if (state !== S_TRACK) left = 1;
        end
        tests++; if (err_skew !== 1'b1 || left || filt !== 4'd6) begin
            fails++; $display("FAIL err_sticky: err=%0b left=%0b filt=%0d need 1/0/6", err_skew, left, filt);
        end
    endtask

    task automatic test_quiet_down();
        int n = 0;
        restart(4'd3, 4'd6);
        skew = 5'd0;
        to_track();
        skew = 5'd3;
        tick();
        skew = 5'd1;
        to_track();
        tests++; if (filt !== 4'd4) begin fails++; $display("FAIL down_pre: filt=%0d need 4", filt); end
        while (state === S_TRACK && n < 400) begin
            n++;
            tick();
        end
        tests++; if (n != QUIET_CYC || state !== S_ADJUST) begin
            fails++; $display("FAIL quiet_len: cycles=%0d state=%0d need %0d/4", n, state, QUIET_CYC);
        end
        tick();
        tests++; if (filt !== 4'd3 || filt_changed !== 1'b1) begin
            fails++; $display("FAIL down_res: filt=%0d chg=%0b need 3/1", filt, filt_changed);
        end
        to_track();
        repeat (300) tick();
        tests++; if (state !== S_TRACK || filt !== 4'd3) begin
            fails++; $display("FAIL down_floor: state=%0d filt=%0d need 3/3", state, filt);
        end
    endtask

    task automatic test_soft_init_and_abort();
        int n = 0;
        bit lowbad = 0;
        restart(4'd2, 4'd6);
        skew = 5'd0;
        to_track();
        skew = 5'd2;
        tick();
        skew = 5'd0;
        to_track();
        soft_init = 1'b1;
        tick();
        soft_init = 1'b0;
        tests++; if (state !== S_INIT || filt !== 4'd3) begin
            fails++; $display("FAIL soft_init: state=%0d filt=%0d need 1/3", state, filt);
        end
        while (state === S_INIT && n < 50) begin
            if (init_n !== 1'b0) lowbad = 1;
            n++;
            tick();
        end
        tests++; if (n != INIT_CYC || lowbad || filt !== 4'd3) begin
            fails++; $display("FAIL soft_len: cycles=%0d lowbad=%0b filt=%0d need %0d/0/3", n, lowbad, filt, INIT_CYC);
        end
        to_track();
        skew = 5'd5;
        tick();
        tests++; if (state !== S_ADJUST) begin fails++; $display("FAIL abort_pre: state=%0d need 4", state); end
        enable = 1'b0;
        skew = 5'd0;
        tick();
        tests++; if (state !== S_IDLE || init_n !== 1'b0 || filt !== 4'd2 || filt_changed !== 1'b0) begin
            fails++; $display("FAIL abort: state=%0d init_n=%0b filt=%0d chg=%0b need 0/0/2/0",
                              state, init_n, filt, filt_changed);
        end
    endtask

    // Reference: age = cycles since TRACK entry; decisions follow the priority list directly.
    task automatic test_random();
        int  m_depth;
        int  m_age;
        int  m_cnt;
        int  need;
        int  hold;
        bit  m_err;
        bit  exp_adj;
        bit  up;
        restart(4'd2, 4'd6);
        skew = 5'd0;
        to_track();
        m_depth = 2; m_age = 0; m_cnt = 0; m_err = 0;
        for (int t = 0; t < 14; t++) begin
            if ($urandom_range(0, 1) == 1) skew = 5'($urandom_range(0, m_depth - 2));
            else                           skew = 5'($urandom_range(0, 7));
            hold = $urandom_range(20, 300);
            exp_adj = 0;
            up = 0;
            for (int k = 0; k < hold && !exp_adj; k++) begin
                avail = 1'($urandom_range(0, 1));
                need  = int'(skew) + SKEW_MARGIN;
                if (avail && m_cnt < 65535) m_cnt++;
                if (need > m_depth && m_depth < 6) begin
                    exp_adj = 1; up = 1;
                end else if (need > m_depth) begin
                    m_err = 1;
                end else if (m_age >= QUIET_CYC - 1 && need < m_depth && m_depth > 2) begin
                    exp_adj = 1; up = 0;
                end
                m_age++;
                tick();
                tests++;
                if (state !== (exp_adj ? S_ADJUST : S_TRACK)) begin
                    fails++;
                    $display("FAIL rnd_state: trial=%0d cyc=%0d state=%0d need %0d",
                             t, k, state, exp_adj ? S_ADJUST : S_TRACK);
                    avail = 1'b0;
                    return;
                end
            end
            avail = 1'b0;
            tests++; if (err_skew !== m_err) begin
                fails++; $display("FAIL rnd_err: trial=%0d got %0b need %0b", t, err_skew, m_err);
            end
            tests++; if (avail_cnt !== 16'(m_cnt)) begin
                fails++; $display("FAIL rnd_cnt: trial=%0d got %0d need %0d", t, avail_cnt, m_cnt);
            end
            if (exp_adj) begin
                m_depth = up ? m_depth + 1 : m_depth - 1;
                skew = 5'd0;
                tick();
                tests++; if (filt !== 4'(m_depth)) begin
                    fails++; $display("FAIL rnd_depth: trial=%0d got %0d need %0d", t, filt, m_depth);
                end
                to_track();
                m_age = 0;
            end else begin
                tests++; if (filt !== 4'(m_depth)) begin
                    fails++; $display("FAIL rnd_hold: trial=%0d got %0d need %0d", t, filt, m_depth);
                end
            end
        end
    endtask

    task automatic test_saturation();
        restart(4'd2, 4'd6);
        skew = 5'd0;
        to_track();
        avail = 1'b1;
        repeat (70000) tick();
        avail = 1'b0;
        tests++; if (state !== S_TRACK || avail_cnt !== 16'hFFFF) begin
            fails++; $display("FAIL sat: state=%0d cnt=%0d need 3/65535", state, avail_cnt);
        end
    endtask

    task automatic test_async_reset();
        soft_init = 1'b1;
        tick();
        soft_init = 1'b0;
        tick();
        tests++; if (state !== S_INIT) begin fails++; $display("FAIL ar_pre: state=%0d need 1", state); end
        #2;
        rst_d = 1'b1;
        #1;
        tests++; if (state !== S_IDLE || init_n !== 1'b0 || filt !== 4'(FILT_RST)) begin
            fails++; $display("FAIL ar_ctrl: state=%0d init_n=%0b filt=%0d need 0/0/%0d", state, init_n, filt, FILT_RST);
        end
        tests++; if (avail_cnt !== '0 || filt_changed !== 1'b0 || err_skew !== 1'b0) begin
            fails++; $display("FAIL ar_stat: cnt=%0d chg=%0b err=%0b need 0/0/0", avail_cnt, filt_changed, err_skew);
        end
        enable = 1'b0;
        tick();
        rst_d = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init_seq();
        test_adjust_up();
        test_err_max();
        test_quiet_down();
        test_soft_init_and_abort();
        test_random();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
